// File: rtl/cpu_pkg.sv
// Shared rename-stage constants: physical/architectural register counts and the physical tag type.
package cpu_pkg;
    localparam int NUM_PHYS_REGS = 64;
    localparam int NUM_ARCH_REGS = 32;
    localparam int PREG_W        = $clog2(NUM_PHYS_REGS);

    typedef logic [PREG_W-1:0] ptag_t;
endpackage

// File: rtl/phys_reg_allocator_tag_fifo.sv
// tag_fifo: circular buffer of free physical tags with show-ahead head data and registered count/empty.
// Reset contents are BASE, BASE+1, ... BASE+DEPTH-1 (full, head == tail == 0).
module tag_fifo #(
    parameter int DEPTH = 32,
    parameter int W     = 6,
    parameter int CNT_W = 7,
    parameter int BASE  = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     head_data,
    output logic [CNT_W-1:0] count,
    output logic             empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CNT_W-1:0] count_next;

    assign head_data = mem[head];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= W'(BASE + i);
            end
            head  <= '0;
            tail  <= '0;
            count <= CNT_W'(DEPTH);
            empty <= 1'b0;
        end else begin
            if (push) begin
                mem[tail] <= push_data;
                tail      <= (tail == PW'(DEPTH - 1)) ? '0 : tail + 1'b1;
            end
            if (pop) begin
                head <= (head == PW'(DEPTH - 1)) ? '0 : head + 1'b1;
            end
            count <= count_next;
            empty <= (count_next == '0);
        end
    end
endmodule

// File: rtl/phys_reg_allocator.sv
// Free physical tag pool for rename: show-ahead grant from a tag FIFO, free bitmap for release checking.
// Optional FREELIST_BYPASS_EN: when empty, a legal release is forwarded straight to a pending alloc.
module phys_reg_allocator
    import cpu_pkg::*;
#(
    parameter int NUM_PHYS = NUM_PHYS_REGS,
    parameter int NUM_ARCH = NUM_ARCH_REGS,
    parameter int TAG_W    = PREG_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alloc_req,
    output logic             alloc_grant,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             release_valid,
    input  logic [TAG_W-1:0] release_tag,
    output logic             empty,
    output logic [TAG_W:0]   free_count,
    output logic             err_release
);
    localparam int DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int CNT_W = TAG_W + 1;

    logic [NUM_PHYS-1:0] free_map;
    logic [TAG_W-1:0]    head_tag;
    logic                rel_nonzero;
    logic                rel_legal;
    logic                rel_illegal;
    logic                bypass;
    logic                push;
    logic                pop;

    tag_fifo #(
        .DEPTH (DEPTH),
        .W     (TAG_W),
        .CNT_W (CNT_W),
        .BASE  (NUM_ARCH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (release_tag),
        .pop       (pop),
        .head_data (head_tag),
        .count     (free_count),
        .empty     (empty)
    );

    // p0 backs x0 and is never returned, so a p0 release is neither legal nor an error.
    assign rel_nonzero = release_valid && (release_tag != '0);
    assign rel_legal   = rel_nonzero && !free_map[release_tag] && (free_count < CNT_W'(DEPTH));
    assign rel_illegal = rel_nonzero && (free_map[release_tag] || (free_count == CNT_W'(DEPTH)));

`ifdef FREELIST_BYPASS_EN
    assign bypass = empty && alloc_req && rel_legal;
`else
    assign bypass = 1'b0;
`endif

    assign pop         = alloc_req && !empty;
    assign push        = rel_legal && !bypass;
    assign alloc_grant = pop || bypass;
    assign alloc_tag   = bypass ? release_tag : head_tag;

    // Popped and pushed tags never collide: one is free, the other is in use.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PHYS; i++) begin
                free_map[i] <= (i >= NUM_ARCH);
            end
            err_release <= 1'b0;
        end else begin
            if (pop) begin
                free_map[head_tag] <= 1'b0;
            end
            if (push) begin
                free_map[release_tag] <= 1'b1;
            end
            if (rel_illegal) begin
                err_release <= 1'b1;
            end
        end
    end
endmodule

// File: doc/phys_reg_allocator.md
# phys_reg_allocator

Manages the pool of free physical register tags for the rename stage. Hands out one tag per cycle to rename and takes back one tag per cycle from retire. Drives the empty indication that rename uses as its free-list stall. Internally it is a circular tag FIFO plus a free bitmap that catches illegal releases.

## Interface
Parameters:
- NUM_PHYS, 64: number of physical registers.
- NUM_ARCH, 32: number of architectural registers; p0..p(NUM_ARCH-1) are mapped at reset.
- TAG_W, 6: tag width, equal to log2(NUM_PHYS).

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- alloc_req  in  1  rename needs a tag for a writing rd this cycle.
- alloc_grant  out  1  a tag is handed out this cycle.
- alloc_tag  out  TAG_W  the granted tag; valid only when alloc_grant=1.
- release_valid  in  1  retire is returning a tag.
- release_tag  in  TAG_W  the tag being returned.
- empty  out  1  no free tag is stored.
- free_count  out  TAG_W+1  number of stored free tags.
- err_release  out  1  sticky; set by an illegal release.

## Operation
- Depth is DEPTH = NUM_PHYS − NUM_ARCH (32).
- Reset contents: FIFO holds p32..p63 in order, head=0, tail=0 (wrapped, full), free_count=32.
- Reset outputs: empty=0, alloc_grant=0, err_release=0, alloc_tag=32.
- Reset free bitmap: bits 32..63 set, bits 0..31 clear.
- Allocate: alloc_grant = alloc_req & ~empty. On grant, head advances and the bitmap bit for alloc_tag clears.
- Release is accepted when release_valid=1, release_tag≠0, the bitmap bit is clear and count<DEPTH.
  - The tag is written at tail, tail advances and the bitmap bit sets.
- p0 release is ignored silently; x0 never owns a renamed register.
- A release is illegal if the tag is already free (double free) or count==DEPTH. An illegal release is dropped and sets err_release, which clears only on reset.
- Pointers are mod DEPTH and wrap from DEPTH−1 to 0.
- free_count next = free_count + accepted_release − grant.
- Simultaneous grant and release in the same cycle are both legal:
  - count is unchanged;
  - a released tag is never handed out in that same cycle unless the bypass below applies.
- Asserting reset mid-operation discards all state and restores the reset contents immediately.

## Timing
- alloc_grant and alloc_tag are combinational from alloc_req and the registered head (show-ahead). There is zero-cycle latency to rename.
- A released tag becomes allocatable from the cycle after release at the earliest. When the FIFO is non-empty it is allocatable only after all older entries are consumed.
- empty and free_count are registered and reflect the state after the previous edge.
- err_release rises on the edge following the offending release.

## Configuration
- FREELIST_BYPASS_EN defined: when empty=1, alloc_req=1 and a legal release are all present in one cycle:
  - alloc_grant=1 and alloc_tag=release_tag;
  - there is no FIFO write or read, and the bitmap bit stays clear.
- FREELIST_BYPASS_EN undefined: in that case alloc_grant=0 and the release is enqueued normally.

## Structure
- Shared package cpu_pkg holds NUM_PHYS_REGS, NUM_ARCH_REGS, PREG_W and the ptag_t typedef. The rename logic uses the same constants.
- One sub-module, tag_fifo: a circular buffer with head/tail/count and push/pop. The bitmap, legality checks and bypass live in phys_reg_allocator.

## Test plan
- Reset then alloc_req held 32 cycles:
  - grants p32..p63 in order;
  - on cycle 33, empty=1, alloc_grant=0 and free_count=0.
- Drain to empty, release p40, then alloc_req next cycle: alloc_tag=40 and free_count returns to 0.
- free_count=10, alloc_req and release p5 in the same cycle:
  - the grant is the head tag, not 5;
  - free_count stays 10 and p5 is granted after the 10 older entries.
- Release p33 while it is still free after reset → dropped, err_release=1 next cycle, free_count unchanged.
- Release p0 → ignored, err_release stays 0.
- Empty with alloc_req and release p7 in one cycle:
  - with FREELIST_BYPASS_EN: grant of tag 7, free_count stays 0;
  - without it: no grant, free_count=1.
- Also: assert reset_n low mid-stream, then check the reset contents return without waiting for a clock edge.
